// File: rtl/board_pkg.sv
// Shared types and geometry for the board mover: 48x17 sprite, 816-word ROM.
package board_pkg;
    localparam int BOARD_W     = 48;
    localparam int BOARD_H     = 17;
    localparam int BOARD_DEPTH = 816;

    typedef enum logic [1:0] {TOP, MOV_DN, BOTTOM, MOV_UP} board_state_t;
    typedef logic [9:0] pix_t;
endpackage

// File: rtl/board_mover_if.sv
// Raster/control bundle between the VGA side and board_mover.
// Handshake: no valid/ready; inputs are sampled every Clk, outputs are valid one cycle later.
interface board_mover_if;
    import board_pkg::*;

    logic         frame_clk;
    logic         trigger;
    pix_t         DrawX;
    pix_t         DrawY;
    pix_t         board_addr;
    logic         is_board;
    pix_t         board_y;
    logic         at_bottom;
    board_state_t state_dbg;

    modport master (
        output frame_clk, trigger, DrawX, DrawY,
        input  board_addr, is_board, board_y, at_bottom, state_dbg
    );

    modport slave (
        input  frame_clk, trigger, DrawX, DrawY,
        output board_addr, is_board, board_y, at_bottom, state_dbg
    );
endinterface

// File: rtl/board_addr_gen.sv
// Combinational sprite bounds check and ROM address (y*48 + x) for the board.
module board_addr_gen
    import board_pkg::*;
#(
    parameter int BOARD_X = 200
) (
    input  pix_t draw_x_i,
    input  pix_t draw_y_i,
    input  pix_t board_y_i,
    output logic in_bounds_o,
    output pix_t addr_o
);
    localparam logic [10:0] X_LO = 11'(BOARD_X);
    localparam logic [10:0] X_HI = 11'(BOARD_X + BOARD_W);

    logic [10:0] y_hi;
    logic        x_in;
    logic        y_in;
    pix_t        x_off;
    pix_t        y_off;

    // Bounds are widened to 11 bits so a board near row 1023 cannot wrap.
    assign y_hi  = {1'b0, board_y_i} + 11'(BOARD_H);
    assign x_in  = ({1'b0, draw_x_i} >= X_LO) && ({1'b0, draw_x_i} < X_HI);
    assign y_in  = (draw_y_i >= board_y_i) && ({1'b0, draw_y_i} < y_hi);
    assign x_off = draw_x_i - X_LO[9:0];
    assign y_off = draw_y_i - board_y_i;

    assign in_bounds_o = x_in && y_in;
    assign addr_o      = (y_off << 5) + (y_off << 4) + x_off;
endmodule

// File: rtl/board_mover.sv
// Moving-platform FSM, position register and registered sprite address output.
// Optional: define BOARD_AUTO_RETURN_EN to make the board rise again when trigger is released.
module board_mover
    import board_pkg::*;
#(
    parameter int BOARD_X = 200,
    parameter int Y_TOP   = 100,
    parameter int Y_BOT   = 160,
    parameter int STEP    = 4
) (
    input logic         Clk,
    input logic         Reset_n,
    board_mover_if.slave bus
);
    localparam logic [10:0] Y_TOP_W = 11'(Y_TOP);
    localparam logic [10:0] Y_BOT_W = 11'(Y_BOT);
    localparam logic [10:0] STEP_W  = 11'(STEP);

    board_state_t state_q, state_d;
    pix_t         board_y_q, board_y_d;
    pix_t         addr_q;
    logic         is_board_q;
    logic         frame_q;
    logic         tick;
    logic [10:0]  dn_sum;
    pix_t         down_y;
    pix_t         up_y;
    logic         in_bounds;
    pix_t         addr_c;

    assign tick   = bus.frame_clk && !frame_q;
    assign dn_sum = {1'b0, board_y_q} + STEP_W;
    assign down_y = (dn_sum >= Y_BOT_W) ? Y_BOT_W[9:0] : dn_sum[9:0];
    assign up_y   = ({1'b0, board_y_q} <= (Y_TOP_W + STEP_W)) ? Y_TOP_W[9:0]
                                                               : board_y_q - STEP_W[9:0];

    always_comb begin
        state_d   = state_q;
        board_y_d = board_y_q;
        if (tick) begin
            unique case (state_q)
                TOP: begin
                    if (bus.trigger) begin
                        board_y_d = down_y;
                        state_d   = (down_y == Y_BOT_W[9:0]) ? BOTTOM : MOV_DN;
                    end
                end
                MOV_DN: begin
`ifdef BOARD_AUTO_RETURN_EN
                    if (!bus.trigger) begin
                        board_y_d = up_y;
                        state_d   = (up_y == Y_TOP_W[9:0]) ? TOP : MOV_UP;
                    end else begin
                        board_y_d = down_y;
                        state_d   = (down_y == Y_BOT_W[9:0]) ? BOTTOM : MOV_DN;
                    end
`else
                    board_y_d = down_y;
                    state_d   = (down_y == Y_BOT_W[9:0]) ? BOTTOM : MOV_DN;
`endif
                end
                BOTTOM: begin
`ifdef BOARD_AUTO_RETURN_EN
                    if (!bus.trigger) state_d = MOV_UP;
`endif
                    board_y_d = Y_BOT_W[9:0];
                end
                MOV_UP: begin
                    // Re-pressing the lever reverses the board on the same tick.
                    if (bus.trigger) begin
                        board_y_d = down_y;
                        state_d   = (down_y == Y_BOT_W[9:0]) ? BOTTOM : MOV_DN;
                    end else begin
                        board_y_d = up_y;
                        state_d   = (up_y == Y_TOP_W[9:0]) ? TOP : MOV_UP;
                    end
                end
                default: begin
                    state_d   = TOP;
                    board_y_d = Y_TOP_W[9:0];
                end
            endcase
        end
    end

    board_addr_gen #(.BOARD_X(BOARD_X)) u_addr_gen (
        .draw_x_i    (bus.DrawX),
        .draw_y_i    (bus.DrawY),
        .board_y_i   (board_y_q),
        .in_bounds_o (in_bounds),
        .addr_o      (addr_c)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= TOP;
            board_y_q  <= Y_TOP_W[9:0];
            addr_q     <= '0;
            is_board_q <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            board_y_q  <= board_y_d;
            addr_q     <= in_bounds ? addr_c : '0;
            is_board_q <= in_bounds;
            frame_q    <= bus.frame_clk;
        end
    end

    assign bus.board_addr = addr_q;
    assign bus.is_board   = is_board_q;
    assign bus.board_y    = board_y_q;
    assign bus.at_bottom  = (state_q == BOTTOM);
    assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_board_mover.sv
// Bench for board_mover: STEP=4 and STEP=7 instances driven in lockstep against a position/geometry model.
module tb_board_mover;
    logic Clk;
    logic Reset_n;

    board_mover_if if4 ();
    board_mover_if if7 ();

    assign if7.frame_clk = if4.frame_clk;
    assign if7.trigger   = if4.trigger;
    assign if7.DrawX     = if4.DrawX;
    assign if7.DrawY     = if4.DrawY;

    board_mover #(.BOARD_X(200), .Y_TOP(100), .Y_BOT(160), .STEP(4)) u_dut4 (
        .Clk(Clk), .Reset_n(Reset_n), .bus(if4.slave)
    );
    board_mover #(.BOARD_X(200), .Y_TOP(100), .Y_BOT(160), .STEP(7)) u_dut7 (
        .Clk(Clk), .Reset_n(Reset_n), .bus(if7.slave)
    );

    // clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // scoreboard state
    int n_checks = 0;
    int n_errors = 0;
    logic [10:0] exp_q[$];

    // reference model: board top row and "resting at bottom" flag per instance
    int stp [2] = '{4, 7};
    int m_y [2] = '{100, 100};
    int m_bot [2] = '{0, 0};
    logic m_fc = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] ref_pixel(input int x, input int y, input int by);
        if (x >= 200 && x < 248 && y >= by && y < by + 17)
            return {1'b1, 10'((y - by) * 48 + (x - 200))};
        return 11'd0;
    endfunction

    task automatic model_tick(input int k, input logic trig);
        if (trig) begin
            m_y[k]   = (m_y[k] + stp[k] > 160) ? 160 : m_y[k] + stp[k];
            m_bot[k] = (m_y[k] == 160) ? 1 : 0;
        end else begin
`ifdef BOARD_AUTO_RETURN_EN
            if (m_bot[k] != 0) m_bot[k] = 0;
            else if (m_y[k] != 100) m_y[k] = (m_y[k] - stp[k] < 100) ? 100 : m_y[k] - stp[k];
`else
            if (m_y[k] != 100) begin
                m_y[k]   = (m_y[k] + stp[k] > 160) ? 160 : m_y[k] + stp[k];
                m_bot[k] = (m_y[k] == 160) ? 1 : 0;
            end
`endif
        end
    endtask

    // driver: one clock with given inputs, then compare both instances
    task automatic cycle(input logic rst_n, input logic fc, input logic trig, input int x, input int y);
        logic [10:0] e;
        Reset_n       = rst_n;
        if4.frame_clk = fc;
        if4.trigger   = trig;
        if4.DrawX     = 10'(x);
        if4.DrawY     = 10'(y);
        for (int k = 0; k < 2; k++)
            exp_q.push_back(rst_n ? ref_pixel(x, y, m_y[k]) : 11'd0);
        if (!rst_n) begin
            m_y   = '{100, 100};
            m_bot = '{0, 0};
            m_fc  = 1'b0;
        end else begin
            if (fc && !m_fc) begin
                model_tick(0, trig);
                model_tick(1, trig);
            end
            m_fc = fc;
        end
        @(posedge Clk);
        #1;
        e = exp_q.pop_front();
        check("s4_is_board", 32'(if4.is_board), 32'(e[10]));
        check("s4_addr", 32'(if4.board_addr), 32'(e[9:0]));
        check("s4_board_y", 32'(if4.board_y), 32'(m_y[0]));
        check("s4_at_bottom", 32'(if4.at_bottom), 32'(m_bot[0]));
        e = exp_q.pop_front();
        check("s7_is_board", 32'(if7.is_board), 32'(e[10]));
        check("s7_addr", 32'(if7.board_addr), 32'(e[9:0]));
        check("s7_board_y", 32'(if7.board_y), 32'(m_y[1]));
        check("s7_at_bottom", 32'(if7.at_bottom), 32'(m_bot[1]));
    endtask

    task automatic tick(input logic trig, input int x, input int y);
        cycle(1'b1, 1'b1, trig, x, y);
        cycle(1'b1, 1'b0, trig, x, y);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 0, 0);
        cycle(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        Reset_n = 1'b0;
        if4.frame_clk = 1'b0;
        if4.trigger   = 1'b0;
        if4.DrawX     = '0;
        if4.DrawY     = '0;
        do_reset();

        // addressing at rest, including the sprite edges
        cycle(1, 0, 0, 200, 100);
        cycle(1, 0, 0, 247, 116);
        cycle(1, 0, 0, 248, 116);
        cycle(1, 0, 0, 199, 100);
        cycle(1, 0, 0, 200, 117);
        cycle(1, 0, 0, 223, 108);
        cycle(1, 0, 0, 200, 99);

        // frame_clk held high: exactly one tick
        for (int i = 0; i < 10; i++) cycle(1, 1, 1, 210, 105);
        cycle(1, 0, 0, 210, 105);
        check("held_high_y", 32'(if4.board_y), 32'd104);
        do_reset();

        // ticks without trigger leave the board at rest
        for (int i = 0; i < 5; i++) tick(0, 210, 105);

        // reset while moving
        for (int i = 0; i < 8; i++) tick(1, 220, 110);
        check("mid_motion_y", 32'(if4.board_y), 32'd132);
        do_reset();

        // full descent with clamping, then hold at bottom
        for (int i = 0; i < 18; i++) tick(1, 200 + i, 100 + 4 * i);
        check("bottom_flag", 32'(if4.at_bottom), 32'd1);
        cycle(1, 0, 1, 210, 176);
        cycle(1, 0, 1, 210, 159);
        cycle(1, 0, 1, 247, 160);
        cycle(1, 0, 1, 200, 177);

        // release at 120, then re-press on the way back
        do_reset();
        for (int i = 0; i < 5; i++) tick(1, 230, 120);
        tick(0, 230, 118);
        tick(0, 230, 114);
        tick(0, 230, 110);
        tick(1, 230, 108);
        for (int i = 0; i < 6; i++) tick(0, 230, 104);
        for (int i = 0; i < 20; i++) tick(1, 205, 150);
        for (int i = 0; i < 20; i++) tick(0, 205, 150);

        // random phase
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) != 0), int'($urandom_range(190, 260)),
                  int'($urandom_range(90, 185)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
